fast_msg_decoder: RTL and testbench
===================================

# fast_msg_decoder

- Parametrised FAST byte-stream decoder for the `clk_fast` domain of the market data engine.
- Adds presence-map (PMAP) handling with per-field copy operators and true stop-bit varint decoding with overflow detection.
- Adds template checking, an inter-byte gap timeout with error resync, and a valid/ready output handshake that backpressures the UDP byte stream.
- Decoded messages are handed to the downstream CDC/order-book path.

## Interface
- TEMPLATE_ID, 1: only accepted template ID.
- SYM_BYTES, 8: raw symbol length in bytes.
- PRICE_W, 32: price width in bits.
- QTY_W, 32: quantity width in bits.
- TS_W, 64: timestamp width in bits.
- GAP_TIMEOUT, 16: idle cycles mid-message that abort the message.
- CNT_W, 32: statistics counter width.
- clk_fast  in  1  the single clock; all logic samples on its rising edge.
- rst  in  1  synchronous, active-high reset.
- udp_data_in  in  8  stream byte.
- udp_valid_in  in  1  byte valid.
- udp_ready_out  out  1  decoder accepts a byte this cycle.
- msg_valid  out  1  decoded message available.
- msg_ready  in  1  consumer accepts the message.
- msg_symbol  out  8*SYM_BYTES  symbol; first byte received is the MSB.
- msg_price, msg_qty, msg_ts  out  PRICE_W/QTY_W/TS_W  decoded values.
- msg_side  out  1  0=buy, 1=sell.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  cause; valid while err_valid is high.
- msg_count, decode_errors  out  CNT_W  statistics counters.

## Operation
- **Byte transfer:** a byte transfers on a cycle where udp_valid_in && udp_ready_out. Every other cycle is a stall.
- **Message layout:** PMAP, template ID, symbol, price, qty, side, ts.
- **PMAP byte:** bit7 must be 1 (stop bit). Presence bits: bit5 symbol, bit4 price, bit3 qty, bit2 side, bit1 ts. bits 6 and 0 are ignored.
- **Absent fields:** an absent field is skipped in the byte stream and copies its previously decoded value. Copy registers reset to 0.
- **Template ID:** always present, encoded as a stop-bit varint.
- **Symbol:** SYM_BYTES raw bytes.
- **Side:** one raw byte.
- **Varints (price, qty, ts, template ID):** each byte does acc = (acc<<7)|byte[6:0]. The field ends on the byte with bit7=1.
  - Maximum length is ceil(W/7) bytes.
- **State machine:** IDLE(expect PMAP) → TID → SYM → PRICE → QTY → SIDE → TS → EMIT. Absent states are skipped; a message that ends after TID is legal.
  - EMIT → IDLE on msg_valid && msg_ready.
- **Error causes:** each cause pulses err_valid, increments decode_errors and produces no message.
  - 1: PMAP bit7=0.
  - 2: template ≠ TEMPLATE_ID.
  - 3: varint overflow, meaning the byte count is exceeded or a 1 bit is shifted beyond W.
  - 4: side byte > 1.
  - 5: gap timeout.
- **After causes 1–4:** go to DISCARD. DISCARD drops bytes (ready stays high) until GAP_TIMEOUT consecutive idle cycles, then goes to IDLE. DISCARD raises no further errors.
- **Gap timer:**
  - Counts cycles without a transfer in TID..TS.
  - Reaching GAP_TIMEOUT gives cause 5 and IDLE, with no discard.
  - The timer clears on every transfer and in IDLE/EMIT.
- **msg_count:** increments on each output handshake. Both counters wrap modulo 2^CNT_W.
- **Copy registers:** update only when a message completes without error. An aborted message leaves them unchanged.

## Timing
- **Reset values:** all outputs 0 except udp_ready_out=1. State is IDLE; counters, copy registers and the gap timer are 0.
- **Latency:** final byte transferred at cycle N → msg_valid=1 at N+1, with fields registered and stable until the handshake.
- **Backpressure:** udp_ready_out=0 for the whole time state=EMIT. The handshake at cycle M gives msg_valid=0 and udp_ready_out=1 at M+1. This is a minimum one-cycle bubble per message.
- **Errors:** err_valid fires in the cycle after the offending byte, or in the cycle after the timer expires.
- **Simultaneous events:** a transfer on the same cycle as timer expiry counts as a transfer; there is no error.
- **Reset mid-message:** state returns to IDLE with no error. Counters and copy registers clear.

## Structure
- **Package fast_pkg:**
  - State enum.
  - Error-code constants ERR_PMAP=1, ERR_TID=2, ERR_OVF=3, ERR_SIDE=4, ERR_GAP=5.
  - PMAP bit positions.
  - ceil-div-by-7 function for the maximum varint byte count.
- **Sub-module fast_varint_acc #(W):** clear/shift-in/stop/overflow accumulator, instanced once per varint width (PRICE_W, QTY_W, TS_W), or once at max width with final truncation.

## Test plan
- **Full message:** bytes BE, 81, "AAPL",00×4, 75 CA, 07 E8, 00, 85 → msg_valid with symbol 0x4141504C_00000000, price 15050, qty 1000, side 0, ts 5; msg_count=1.
- **Copy operator:** next message 90, 81, 75 CF → price 15055; symbol, qty 1000, side 0 and ts 5 are copied.
- **Bad template:** template byte 82 → err_code 2, rest discarded. After 16 idle cycles the test-1 message decodes; decode_errors=1, msg_count=2.
- **Varint overflow:** price bytes 01×5 then 81 → err_code 3 on the 6th byte.
- **Backpressure:** msg_ready held low 5 cycles after msg_valid → udp_ready_out=0, fields stable, no bytes consumed. The handshake is followed by ready=1 the next cycle.
- **Gap and reset:**
  - valid dropped 16 cycles mid-qty → err_code 5, then IDLE.
  - rst asserted mid-symbol → no error pulse, counters 0, and the next full message decodes correctly.

Source files
------------

// File: rtl/fast_pkg.sv
// Shared types and helpers for the FAST message decoder.
// States, error codes, PMAP bit positions and varint sizing.
package fast_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TID,
    S_SYM,
    S_PRICE,
    S_QTY,
    S_SIDE,
    S_TS,
    S_EMIT,
    S_DISCARD
  } state_t;

  localparam logic [2:0] ERR_PMAP = 3'd1;
  localparam logic [2:0] ERR_TID  = 3'd2;
  localparam logic [2:0] ERR_OVF  = 3'd3;
  localparam logic [2:0] ERR_SIDE = 3'd4;
  localparam logic [2:0] ERR_GAP  = 3'd5;

  localparam int PM_SYM   = 5;
  localparam int PM_PRICE = 4;
  localparam int PM_QTY   = 3;
  localparam int PM_SIDE  = 2;
  localparam int PM_TS    = 1;

  localparam int TID_W = 14;

  function automatic int vmax_bytes(int w);
    return (w + 6) / 7;
  endfunction

  // First present field after s; EMIT when none remain.
  function automatic state_t next_after(
    state_t s,
    logic [5:1] pm
  );
    state_t n;
    n = S_EMIT;
    if (s < S_TS && pm[PM_TS]) n = S_TS;
    if (s < S_SIDE && pm[PM_SIDE]) n = S_SIDE;
    if (s < S_QTY && pm[PM_QTY]) n = S_QTY;
    if (s < S_PRICE && pm[PM_PRICE]) n = S_PRICE;
    if (s < S_SYM && pm[PM_SYM]) n = S_SYM;
    return n;
  endfunction

endpackage

// File: rtl/fast_varint_acc.sv
// Stop-bit varint accumulator with byte-count and bit-loss overflow.
// value/ovf describe the result of shifting in the current byte.
module fast_varint_acc
  import fast_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_fast,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift,
  input  logic [6:0]   din,
  output logic [W-1:0] value,
  output logic         ovf
);
  localparam int MAXB = vmax_bytes(W);
  localparam int CW = $clog2(MAXB + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAXB);

  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;

  assign value = {acc[W-8:0], din};
  assign ovf = (cnt == CMAX) || (|acc[W-1 -: 7]);

  always_ff @(posedge clk_fast) begin
    if (rst || clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (shift) begin
      acc <= value;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fast_msg_decoder.sv
// FAST market-data byte-stream decoder: PMAP, copy operators, varints.
// Hands decoded messages downstream over a valid/ready handshake.
module fast_msg_decoder
  import fast_pkg::*;
#(
  parameter int TEMPLATE_ID = 1,
  parameter int SYM_BYTES   = 8,
  parameter int PRICE_W     = 32,
  parameter int QTY_W       = 32,
  parameter int TS_W        = 64,
  parameter int GAP_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                   clk_fast,
  input  logic                   rst,
  input  logic [7:0]             udp_data_in,
  input  logic                   udp_valid_in,
  output logic                   udp_ready_out,
  output logic                   msg_valid,
  input  logic                   msg_ready,
  output logic [8*SYM_BYTES-1:0] msg_symbol,
  output logic [PRICE_W-1:0]     msg_price,
  output logic [QTY_W-1:0]       msg_qty,
  output logic [TS_W-1:0]        msg_ts,
  output logic                   msg_side,
  output logic                   err_valid,
  output logic [2:0]             err_code,
  output logic [CNT_W-1:0]       msg_count,
  output logic [CNT_W-1:0]       decode_errors
);
  localparam int SW = 8 * SYM_BYTES;
  localparam int SCW = (SYM_BYTES > 1) ? $clog2(SYM_BYTES) : 1;
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [SCW-1:0] SYM_LAST = SCW'(SYM_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

  state_t state, state_nxt;

  logic           xfer, stop, in_msg, gap_hit;
  logic           err_now, v_ovf;
  logic [2:0]     err_nxt;
  logic [5:1]     pm;
  logic [SCW-1:0] sym_cnt;
  logic [GW-1:0]  gap_cnt;

  logic [SW-1:0]      sym_q, sym_d;
  logic [PRICE_W-1:0] px_q, px_d, px_val;
  logic [QTY_W-1:0]   qty_q, qty_d, qty_val;
  logic [TS_W-1:0]    ts_q, ts_d, ts_val;
  logic               side_q, side_d;
  logic [TID_W-1:0]   tid_val;
  logic               tid_ovf, px_ovf, qty_ovf, ts_ovf;

  assign xfer = udp_valid_in && udp_ready_out;
  assign stop = udp_data_in[7];
  assign in_msg = state inside {S_TID, S_SYM, S_PRICE,
                                S_QTY, S_SIDE, S_TS};
  assign gap_hit = !xfer && (gap_cnt == GAP_LAST);
  assign v_ovf = (state == S_PRICE && px_ovf)
              || (state == S_QTY && qty_ovf)
              || (state == S_TS && ts_ovf);

  fast_varint_acc #(.W(TID_W)) u_tid (
    .clk_fast(clk_fast), .rst(rst),
    .clr(state != S_TID),
    .shift(xfer && state == S_TID),
    .din(udp_data_in[6:0]),
    .value(tid_val), .ovf(tid_ovf)
  );

  fast_varint_acc #(.W(PRICE_W)) u_px (
    .clk_fast(clk_fast), .rst(rst),
    .clr(state != S_PRICE),
    .shift(xfer && state == S_PRICE),
    .din(udp_data_in[6:0]),
    .value(px_val), .ovf(px_ovf)
  );

  fast_varint_acc #(.W(QTY_W)) u_qty (
    .clk_fast(clk_fast), .rst(rst),
    .clr(state != S_QTY),
    .shift(xfer && state == S_QTY),
    .din(udp_data_in[6:0]),
    .value(qty_val), .ovf(qty_ovf)
  );

  fast_varint_acc #(.W(TS_W)) u_ts (
    .clk_fast(clk_fast), .rst(rst),
    .clr(state != S_TS),
    .shift(xfer && state == S_TS),
    .din(udp_data_in[6:0]),
    .value(ts_val), .ovf(ts_ovf)
  );

  always_ff @(posedge clk_fast) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_now = 1'b0;
    err_nxt = '0;
    unique case (state)
      S_IDLE: if (xfer) begin
        if (!stop) begin
          err_now = 1'b1;
          err_nxt = ERR_PMAP;
        end else begin
          state_nxt = S_TID;
        end
      end
      S_TID: if (xfer) begin
        if (tid_ovf) begin
          err_now = 1'b1;
          err_nxt = ERR_OVF;
        end else if (stop && tid_val != TID_W'(TEMPLATE_ID)) begin
          err_now = 1'b1;
          err_nxt = ERR_TID;
        end else if (stop) begin
          state_nxt = next_after(S_TID, pm);
        end
      end
      S_SYM: if (xfer && sym_cnt == SYM_LAST) begin
        state_nxt = next_after(S_SYM, pm);
      end
      S_PRICE, S_QTY, S_TS: if (xfer) begin
        if (v_ovf) begin
          err_now = 1'b1;
          err_nxt = ERR_OVF;
        end else if (stop) begin
          state_nxt = next_after(state, pm);
        end
      end
      S_SIDE: if (xfer) begin
        if (|udp_data_in[7:1]) begin
          err_now = 1'b1;
          err_nxt = ERR_SIDE;
        end else begin
          state_nxt = next_after(S_SIDE, pm);
        end
      end
      S_EMIT: if (msg_ready) state_nxt = S_IDLE;
      S_DISCARD: if (gap_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (err_now) state_nxt = S_DISCARD;
    // Stalled mid-message: abort straight to IDLE, no discard.
    if (in_msg && gap_hit) begin
      err_now = 1'b1;
      err_nxt = ERR_GAP;
      state_nxt = S_IDLE;
    end
  end

  always_comb begin
    udp_ready_out = (state != S_EMIT);
    msg_valid = (state == S_EMIT);
  end

  // Working copy starts from the last good message on each PMAP.
  always_comb begin
    sym_d = sym_q;
    px_d = px_q;
    qty_d = qty_q;
    side_d = side_q;
    ts_d = ts_q;
    if (xfer) begin
      unique case (state)
        S_IDLE: begin
          sym_d = msg_symbol;
          px_d = msg_price;
          qty_d = msg_qty;
          side_d = msg_side;
          ts_d = msg_ts;
        end
        S_SYM: sym_d = {sym_q[SW-9:0], udp_data_in};
        S_PRICE: if (stop) px_d = px_val;
        S_QTY: if (stop) qty_d = qty_val;
        S_SIDE: side_d = udp_data_in[0];
        S_TS: if (stop) ts_d = ts_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      pm <= '0;
      sym_cnt <= '0;
      gap_cnt <= '0;
      sym_q <= '0;
      px_q <= '0;
      qty_q <= '0;
      side_q <= 1'b0;
      ts_q <= '0;
      msg_symbol <= '0;
      msg_price <= '0;
      msg_qty <= '0;
      msg_side <= 1'b0;
      msg_ts <= '0;
      err_valid <= 1'b0;
      err_code <= '0;
      msg_count <= '0;
      decode_errors <= '0;
    end else begin
      err_valid <= err_now;
      err_code <= err_nxt;
      if (err_now) decode_errors <= decode_errors + CNT_W'(1);
      if (msg_valid && msg_ready) msg_count <= msg_count + CNT_W'(1);
      if (xfer && state == S_IDLE) pm <= udp_data_in[5:1];
      sym_cnt <= (state == S_SYM) ? sym_cnt + SCW'(xfer) : '0;
      gap_cnt <= (xfer || !(in_msg || state == S_DISCARD))
               ? '0 : gap_cnt + GW'(1);
      sym_q <= sym_d;
      px_q <= px_d;
      qty_q <= qty_d;
      side_q <= side_d;
      ts_q <= ts_d;
      if (state_nxt == S_EMIT && state != S_EMIT) begin
        msg_symbol <= sym_d;
        msg_price <= px_d;
        msg_qty <= qty_d;
        msg_side <= side_d;
        msg_ts <= ts_d;
      end
    end
  end

endmodule

// File: tb/tb_fast_msg_decoder.sv
// Directed bench for fast_msg_decoder.
// Hand-computed FAST byte vectors and expected decoded fields.
module tb_fast_msg_decoder;
  typedef logic [7:0] bq_t[$];

  logic        clk_fast = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  udp_data_in = '0;
  logic        udp_valid_in = 1'b0;
  logic        udp_ready_out;
  logic        msg_valid;
  logic        msg_ready = 1'b0;
  logic [63:0] msg_symbol;
  logic [31:0] msg_price;
  logic [31:0] msg_qty;
  logic [63:0] msg_ts;
  logic        msg_side;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [31:0] msg_count;
  logic [31:0] decode_errors;

  int checks = 0;
  int errors = 0;
  int exp_msgs = 0;
  bq_t m1;
  localparam logic [63:0] SYM1 = 64'h4141504C_00000000;

  always #5 clk_fast = ~clk_fast;

  fast_msg_decoder dut (
    .clk_fast(clk_fast),
    .rst(rst),
    .udp_data_in(udp_data_in),
    .udp_valid_in(udp_valid_in),
    .udp_ready_out(udp_ready_out),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .msg_symbol(msg_symbol),
    .msg_price(msg_price),
    .msg_qty(msg_qty),
    .msg_ts(msg_ts),
    .msg_side(msg_side),
    .err_valid(err_valid),
    .err_code(err_code),
    .msg_count(msg_count),
    .decode_errors(decode_errors)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    udp_data_in = b;
    udp_valid_in = 1'b1;
    while (!udp_ready_out && n < 50) begin
      @(posedge clk_fast); #1;
      n++;
    end
    if (!udp_ready_out) chk("send_timeout", 0, 1);
    @(posedge clk_fast); #1;
    udp_valid_in = 1'b0;
  endtask

  task automatic send_q(input bq_t q);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic idle(input int n);
    udp_valid_in = 1'b0;
    repeat (n) @(posedge clk_fast);
    #1;
  endtask

  task automatic expect_err(input string tag, input logic [2:0] code);
    chk({tag, "_ev"}, err_valid, 1);
    chk({tag, "_code"}, err_code, code);
  endtask

  task automatic take(input string tag,
                      input logic [63:0] sym,
                      input logic [31:0] px,
                      input logic [31:0] qty,
                      input logic sd,
                      input logic [63:0] ts);
    int n = 0;
    while (!msg_valid && n < 40) begin
      @(posedge clk_fast); #1;
      n++;
    end
    chk({tag, "_valid"}, msg_valid, 1);
    chk({tag, "_sym"}, msg_symbol, sym);
    chk({tag, "_px"}, msg_price, px);
    chk({tag, "_qty"}, msg_qty, qty);
    chk({tag, "_side"}, msg_side, sd);
    chk({tag, "_ts"}, msg_ts, ts);
    msg_ready = 1'b1;
    @(posedge clk_fast); #1;
    msg_ready = 1'b0;
    exp_msgs++;
    chk({tag, "_bubble"}, msg_valid, 0);
    chk({tag, "_rdy"}, udp_ready_out, 1);
    chk({tag, "_cnt"}, msg_count, exp_msgs);
  endtask

  initial begin
    m1 = '{8'hBE, 8'h81, 8'h41, 8'h41, 8'h50, 8'h4C,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h75, 8'hCA,
           8'h07, 8'hE8, 8'h00, 8'h85};
    repeat (2) @(posedge clk_fast);
    #1;
    chk("rst_rdy", udp_ready_out, 1);
    chk("rst_mv", msg_valid, 0);
    chk("rst_ev", err_valid, 0);
    chk("rst_cnt", msg_count, 0);
    chk("rst_errs", decode_errors, 0);
    chk("rst_px", msg_price, 0);
    rst = 1'b0;

    send_q(m1);
    chk("m1_lat", msg_valid, 1);
    take("m1", SYM1, 15050, 1000, 0, 5);

    send(8'h90); send(8'h81); send(8'h75); send(8'hCF);
    take("copy", SYM1, 15055, 1000, 0, 5);

    send(8'hBE); send(8'h82);
    expect_err("tid", 2);
    for (int i = 2; i < m1.size(); i++) send(m1[i]);
    chk("disc_ev", err_valid, 0);
    chk("disc_rdy", udp_ready_out, 1);
    chk("tid_errs", decode_errors, 1);
    idle(16);
    send_q(m1);
    take("resync", SYM1, 15050, 1000, 0, 5);
    chk("resync_errs", decode_errors, 1);

    send(8'h90); send(8'h81);
    repeat (5) send(8'h01);
    chk("ovf_5b", err_valid, 0);
    send(8'h81);
    expect_err("ovf", 3);
    chk("ovf_errs", decode_errors, 2);
    idle(16);
    send(8'h80); send(8'h81);
    take("tid_only", SYM1, 15050, 1000, 0, 5);

    send(8'h84); send(8'h81); send(8'h02);
    expect_err("side", 4);
    chk("side_errs", decode_errors, 3);
    idle(16);

    send_q(m1);
    udp_valid_in = 1'b1;
    udp_data_in = 8'h00;
    repeat (5) begin
      chk("bp_rdy", udp_ready_out, 0);
      chk("bp_px", msg_price, 15050);
      chk("bp_mv", msg_valid, 1);
      @(posedge clk_fast); #1;
    end
    udp_valid_in = 1'b0;
    take("bp", SYM1, 15050, 1000, 0, 5);
    chk("bp_errs", decode_errors, 3);

    send(8'h90); send(8'h81);
    idle(15);
    send(8'h75);
    chk("edge_ev", err_valid, 0);
    send(8'hCF);
    take("edge", SYM1, 15055, 1000, 0, 5);

    for (int i = 0; i < 10; i++) send(m1[i]);
    send(8'h01); send(8'h81); send(8'h07);
    idle(15);
    chk("gap_early", err_valid, 0);
    idle(1);
    expect_err("gap", 5);
    chk("gap_errs", decode_errors, 4);
    send(8'h80); send(8'h81);
    take("after_gap", SYM1, 15055, 1000, 0, 5);

    send(8'hBE); send(8'h81); send(8'h41); send(8'h41);
    rst = 1'b1;
    @(posedge clk_fast); #1;
    chk("mrst_ev", err_valid, 0);
    chk("mrst_cnt", msg_count, 0);
    chk("mrst_errs", decode_errors, 0);
    chk("mrst_px", msg_price, 0);
    chk("mrst_rdy", udp_ready_out, 1);
    rst = 1'b0;
    exp_msgs = 0;
    send_q(m1);
    take("post_rst", SYM1, 15050, 1000, 0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
